fp_mul_accumulator: RTL and testbench

//  Downstream consumer of the FP multiplier. Sums a stream of IEEE-754 products into one running total (dot-product / MAC reduction).

---
 rtl/fp_acc_if.sv | 15 +
 rtl/fp_mul_accumulator.sv | 224 ++++++++++++++++++++++
 tb/tb_fp_mul_accumulator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_acc_if.sv
// Valid/ready stream bundle for the FP accumulator: product input side and total output side.
interface fp_acc_if #(parameter int N = 32);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   modport master (output in_valid, in_data, in_last, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/fp_mul_accumulator.sv
// Multi-cycle IEEE-754 accumulator (no rounding, subnormals flushed) summing a product stream.
// Optional FP_ACC_FLAGS_EN adds sticky flag_ovf/flag_unf/flag_nan outputs per reduction.
//
// state | meaning
// IDLE  | ready for a product; capture in_data/in_last
// ALIGN | resolve specials, else order operands and align smaller mantissa
// ADD   | add or subtract aligned mantissas
// NORM  | normalise one bit per cycle, then write acc
// OUT   | hold finished total until out_ready
module fp_mul_accumulator #(
   parameter int N = 32
) (
   input  logic    clk,
   input  logic    rst,
   fp_acc_if.slave bus,
   output logic    busy
`ifdef FP_ACC_FLAGS_EN
   ,
   output logic    flag_ovf,
   output logic    flag_unf,
   output logic    flag_nan
`endif
);
   localparam int E = (N == 64) ? 11 : 8;
   localparam int M = N - E - 1;
   localparam int W = M + 4;
   localparam logic [E-1:0]          EMAX      = '1;
   localparam logic [E-1:0]          SHIFT_OUT = E'(M + 3);
   localparam logic signed [E+1:0]   EXP_MAX   = (E+2)'((2 ** E) - 1);
   localparam logic signed [E+1:0]   EXP_ONE   = (E+2)'(1);
   localparam logic [N-1:0]          NAN_WORD  = {1'b0, EMAX, {M{1'b1}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
   state_t state, nstate;

   logic [N-1:0]          acc, in_q, out_q;
   logic                  last_q, sign_r, sub_r;
   logic [W-1:0]          mant, mant_b;
   logic signed [E+1:0]   exp_r;

   logic          sa, sb;
   logic [E-1:0]  ea, eb;
   logic [M-1:0]  ma, mb;
   assign {sa, ea, ma} = acc;
   assign {sb, eb, mb} = in_q;

   logic          a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
   logic          spec_hit, spec_nan;
   logic [N-1:0]  spec_res;

   always_comb begin
      a_zero   = (ea == '0);
      b_zero   = (eb == '0);
      a_nan    = (ea == EMAX) && (ma != '0);
      b_nan    = (eb == EMAX) && (mb != '0);
      a_inf    = (ea == EMAX) && (ma == '0);
      b_inf    = (eb == EMAX) && (mb == '0);
      spec_hit = 1'b1;
      spec_nan = 1'b0;
      spec_res = acc;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         spec_res = NAN_WORD;
         spec_nan = 1'b1;
      end else if (a_inf) begin
         spec_res = acc;
      end else if (b_inf) begin
         spec_res = in_q;
      end else if (b_zero) begin
         spec_res = a_zero ? '0 : acc;
      end else if (a_zero) begin
         spec_res = in_q;
      end else begin
         spec_hit = 1'b0;
      end
   end

   logic          swap, s_big;
   logic [E-1:0]  e_big, e_sml, diff;
   logic [M-1:0]  m_big, m_sml;
   logic [W-1:0]  sml_sh;

   always_comb begin
      swap   = {eb, mb} > {ea, ma};
      s_big  = swap ? sb : sa;
      e_big  = swap ? eb : ea;
      m_big  = swap ? mb : ma;
      e_sml  = swap ? ea : eb;
      m_sml  = swap ? ma : mb;
      diff   = e_big - e_sml;
      sml_sh = (diff >= SHIFT_OUT) ? '0 : ({2'b01, m_sml, 2'b00} >> diff);
   end

   // A carry finishes in the same cycle as its shift; otherwise shift left until the hidden bit is set.
   logic                  norm_done, norm_ovf, norm_unf;
   logic [N-1:0]          norm_res;
   logic [W-1:0]          m_fin;
   logic signed [E+1:0]   e_fin;

   always_comb begin
      norm_done = 1'b0;
      norm_ovf  = 1'b0;
      norm_unf  = 1'b0;
      norm_res  = '0;
      m_fin     = mant;
      e_fin     = exp_r;
      if (mant == '0) begin
         norm_done = 1'b1;
      end else if (mant[W-1]) begin
         m_fin     = mant >> 1;
         e_fin     = exp_r + EXP_ONE;
         norm_done = 1'b1;
      end else if (mant[W-2]) begin
         norm_done = 1'b1;
      end
      if (norm_done && (mant != '0)) begin
         if (e_fin >= EXP_MAX) begin
            norm_res = {sign_r, EMAX, {M{1'b0}}};
            norm_ovf = 1'b1;
         end else if (e_fin < EXP_ONE) begin
            norm_unf = 1'b1;
         end else begin
            norm_res = {sign_r, e_fin[E-1:0], m_fin[M+1:2]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate        = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) nstate = ALIGN;
         end
         ALIGN: begin
            if (spec_hit) nstate = last_q ? OUT : IDLE;
            else          nstate = ADD;
         end
         ADD:  nstate = NORM;
         NORM: if (norm_done) nstate = last_q ? OUT : IDLE;
         OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   assign bus.out_data = out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         in_q   <= '0;
         out_q  <= '0;
         last_q <= 1'b0;
         sign_r <= 1'b0;
         sub_r  <= 1'b0;
         mant   <= '0;
         mant_b <= '0;
         exp_r  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               in_q   <= bus.in_data;
               last_q <= bus.in_last;
            end
            ALIGN: begin
               if (spec_hit) begin
                  acc <= spec_res;
                  if (last_q) out_q <= spec_res;
               end else begin
                  mant   <= {2'b01, m_big, 2'b00};
                  mant_b <= sml_sh;
                  exp_r  <= {2'b00, e_big};
                  sign_r <= s_big;
                  sub_r  <= sa ^ sb;
               end
            end
            ADD: mant <= sub_r ? (mant - mant_b) : (mant + mant_b);
            NORM: begin
               if (norm_done) begin
                  acc <= norm_res;
                  if (last_q) out_q <= norm_res;
               end else begin
                  mant  <= mant << 1;
                  exp_r <= exp_r - EXP_ONE;
               end
            end
            OUT: if (bus.out_ready) acc <= '0;
            default: ;
         endcase
      end
   end

`ifdef FP_ACC_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_ovf <= 1'b0;
         flag_unf <= 1'b0;
         flag_nan <= 1'b0;
      end else if (state == OUT && bus.out_ready) begin
         flag_ovf <= 1'b0;
         flag_unf <= 1'b0;
         flag_nan <= 1'b0;
      end else begin
         if (state == ALIGN && spec_hit && spec_nan) flag_nan <= 1'b1;
         if (state == NORM && norm_done && norm_ovf) flag_ovf <= 1'b1;
         if (state == NORM && norm_done && norm_unf) flag_unf <= 1'b1;
      end
   end
`else
   logic unused_flag_events;
   assign unused_flag_events = ^{spec_nan, norm_ovf, norm_unf};
`endif
endmodule

// File: tb/tb_fp_mul_accumulator.sv
// Directed bench for fp_mul_accumulator: two-beat vector table plus hand sequences for
// multi-beat, backpressure, reset-in-NORM and the N=64 build.
module tb_fp_mul_accumulator;
   logic clk = 1'b0;
   logic rst;
   logic busy, busy64;
   int   n_vec = 0;
   int   n_err = 0;

   fp_acc_if #(.N(32)) bus ();
   fp_acc_if #(.N(64)) bus64 ();

`ifdef FP_ACC_FLAGS_EN
   logic       f_ovf, f_unf, f_nan, f64_ovf, f64_unf, f64_nan;
   logic [2:0] flags_seen;
`endif

   fp_mul_accumulator #(.N(32)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy)
`ifdef FP_ACC_FLAGS_EN
      , .flag_ovf(f_ovf), .flag_unf(f_unf), .flag_nan(f_nan)
`endif
   );

   fp_mul_accumulator #(.N(64)) dut64 (
      .clk(clk), .rst(rst), .bus(bus64), .busy(busy64)
`ifdef FP_ACC_FLAGS_EN
      , .flag_ovf(f64_ovf), .flag_unf(f64_unf), .flag_nan(f64_nan)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      logic [2:0]  fl;   // {ovf, unf, nan}
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic send(input bit w64, input logic [63:0] d, input logic l);
      int t;
      t = 0;
      @(negedge clk);
      while (!(w64 ? bus64.in_ready : bus.in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_vec++;
         n_err++;
         $display("FAIL in_ready_timeout: got 0, required 1");
         return;
      end
      if (w64) begin
         bus64.in_valid = 1'b1; bus64.in_data = d; bus64.in_last = l;
      end else begin
         bus.in_valid = 1'b1; bus.in_data = d[31:0]; bus.in_last = l;
      end
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus64.in_valid = 1'b0;
   endtask

   // Wait for out_valid (cycles counted in negedges after the accepting edge), optionally stall, then handshake.
   task automatic recv(input bit w64, input int hold, output logic [63:0] d, output int cyc);
      bit ok;
      cyc = 0;
      d   = 'x;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(w64 ? bus64.out_valid : bus.out_valid) && cyc < 300);
      if (!(w64 ? bus64.out_valid : bus.out_valid)) begin
         n_vec++;
         n_err++;
         $display("FAIL out_valid_timeout: got 0, required 1");
         return;
      end
      d = w64 ? bus64.out_data : {32'h0, bus.out_data};
`ifdef FP_ACC_FLAGS_EN
      flags_seen = {f_ovf, f_unf, f_nan};
`endif
      if (hold > 0) begin
         ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.out_data !== d[31:0] || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
         end
         check("backpressure_hold", 64'(ok), 64'(1));
      end
      if (w64) bus64.out_ready = 1'b1;
      else     bus.out_ready   = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready   = 1'b0;
      bus64.out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] d;
      int          cyc;

      vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000,  4, 3'b000};
      vecs[1]  = '{32'h40400000, 32'hC0400000, 32'h00000000,  4, 3'b000};
      vecs[2]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h3FFFFFFF,  4, 3'b000};
      vecs[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FFFFFFF,  2, 3'b001};
      vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000,  4, 3'b100};
      vecs[5]  = '{32'h3F800000, 32'h33800000, 32'h3F800000,  4, 3'b000};
      vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF,  2, 3'b001};
      vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000,  2, 3'b000};
      vecs[8]  = '{32'h00000000, 32'h80000000, 32'h00000000,  2, 3'b000};
      vecs[9]  = '{32'h00000001, 32'h40A00000, 32'h40A00000,  2, 3'b000};
      vecs[10] = '{32'h40A00000, 32'hC0400000, 32'h40000000,  5, 3'b000};
      vecs[11] = '{32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 28, 3'b000};
      vecs[12] = '{32'h00800001, 32'h80800000, 32'h00000000, 27, 3'b010};
      vecs[13] = '{32'hC0000000, 32'hC0000000, 32'hC0800000,  4, 3'b000};

      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_last = 1'b0; bus64.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(bus.in_ready),  64'(1));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_data",  64'(bus.out_data),  64'(0));
      check("rst_busy",      64'(busy),          64'(0));
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         send(1'b0, 64'(vecs[i].a), 1'b0);
         send(1'b0, 64'(vecs[i].b), 1'b1);
         recv(1'b0, 0, d, cyc);
         check($sformatf("vec%0d_result", i), d, 64'(vecs[i].res));
         check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(vecs[i].lat));
`ifdef FP_ACC_FLAGS_EN
         check($sformatf("vec%0d_flags", i), 64'(flags_seen), 64'(vecs[i].fl));
`endif
      end

      // Three-beat reduction: 1 + 1 + 1 = 3
      send(1'b0, 64'h3F800000, 1'b0);
      send(1'b0, 64'h3F800000, 1'b0);
      send(1'b0, 64'h3F800000, 1'b1);
      recv(1'b0, 0, d, cyc);
      check("three_beat", d, 64'h40400000);

      // Single-beat reductions: -0 normalises to +0, a normal value passes through
      send(1'b0, 64'h80000000, 1'b1);
      recv(1'b0, 0, d, cyc);
      check("single_neg_zero", d, 64'h00000000);
      send(1'b0, 64'h40000000, 1'b1);
      recv(1'b0, 0, d, cyc);
      check("single_two", d, 64'h40000000);
      check("single_latency", 64'(cyc), 64'(2));

      // Backpressure: total held 10 cycles, then next reduction starts from +0
      send(1'b0, 64'h3F800000, 1'b0);
      send(1'b0, 64'h40000000, 1'b1);
      recv(1'b0, 10, d, cyc);
      check("bp_result", d, 64'h40400000);
      check("bp_released_out_valid", 64'(bus.out_valid), 64'(0));
      check("bp_released_in_ready",  64'(bus.in_ready),  64'(1));
      send(1'b0, 64'h3F800000, 1'b1);
      recv(1'b0, 0, d, cyc);
      check("bp_fresh_start", d, 64'h3F800000);

      // Reset asserted while NORM is shifting the 2^-24 cancellation residue
      send(1'b0, 64'h3F800000, 1'b0);
      send(1'b0, 64'hBF7FFFFF, 1'b1);
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      check("mid_rst_busy",      64'(busy),          64'(0));
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
      @(negedge clk);
      rst = 1'b0;
      send(1'b0, 64'h40000000, 1'b1);
      recv(1'b0, 0, d, cyc);
      check("post_rst_beat", d, 64'h40000000);

      // N=64: 1.0 + 2.0 = 3.0
      send(1'b1, 64'h3FF0000000000000, 1'b0);
      send(1'b1, 64'h4000000000000000, 1'b1);
      recv(1'b1, 0, d, cyc);
      check("n64_sum", d, 64'h4008000000000000);
      check("n64_latency", 64'(cyc), 64'(4));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
